// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns a single-cycle memory-stage access into a
// request/address-ok/data-ok bus transaction, stalling the pipeline meanwhile.
module dmem_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_sel_i,
    input  logic        flush_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_wr_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_addr_ok_i,
    input  logic        bus_data_ok_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                cancel_q, cancel_d;
    logic                accept_c;
    logic                capture_c;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [SEL_W-1:0]    sel_q;

    // State, cancel flag, request latch and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cancel_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            if (accept_c) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                sel_q   <= req_sel_i;
            end
            if (capture_c) begin
                rdata_q <= bus_rdata_i;
            end
        end
    end

    // Next-state logic; a flush during an outstanding access only marks it
    // cancelled, the bus transaction itself always runs to data_ok.
    always_comb begin
        state_d   = state_q;
        cancel_d  = cancel_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_en_i && !flush_i) begin
                    accept_c = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_i) cancel_d = 1'b1;
                if (bus_addr_ok_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus_data_ok_i) begin
                    if (cancel_q || flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        capture_c = 1'b1;
                        state_d   = S_DONE;
                    end
                end else if (flush_i) begin
                    cancel_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_IDLE) cancel_d = 1'b0;
    end

    // Stall must rise in the same cycle the request is seen, so it is decoded
    // from the inputs as well as the state.
    assign stall_o     = (state_q == S_REQ) || (state_q == S_WAIT) ||
                         ((state_q == S_IDLE) && req_en_i && !flush_i);
    assign rdata_o     = rdata_q;
    assign bus_req_o   = (state_q == S_REQ);
    assign bus_wr_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wstrb_o = we_q ? sel_q : SEL_W'(0);
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en_i, req_we_i, flush_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_sel_i;
    logic [31:0] rdata_o;
    logic        stall_o, bus_req_o, bus_wr_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_addr_ok_i, bus_data_ok_i;
    logic [31:0] bus_rdata_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .req_en_i     (req_en_i),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_sel_i    (req_sel_i),
        .flush_i      (flush_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .bus_req_o    (bus_req_o),
        .bus_wr_o     (bus_wr_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wstrb_o  (bus_wstrb_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_addr_ok_i(bus_addr_ok_i),
        .bus_data_ok_i(bus_data_ok_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    // Reference model: where the single outstanding access stands
    // (0 none, 1 waiting for address acceptance, 2 waiting for data, 3 done).
    int          m_phase;
    bit          m_cancel;
    bit          m_we;
    bit [31:0]   m_addr, m_wdata, m_rdata;
    bit [3:0]    m_sel;

    function automatic void model_reset();
        m_phase = 0; m_cancel = 0; m_we = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_sel = 0;
    endfunction

    function automatic void model_clock();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_phase == 0) begin
            if (req_en_i && !flush_i) begin
                m_we = req_we_i; m_addr = req_addr_i;
                m_wdata = req_wdata_i; m_sel = req_sel_i;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (flush_i) m_cancel = 1;
            if (bus_addr_ok_i) m_phase = 2;
        end else if (m_phase == 2) begin
            if (bus_data_ok_i) begin
                if (m_cancel || flush_i) begin
                    m_phase = 0;
                end else begin
                    m_rdata = bus_rdata_i;
                    m_phase = 3;
                end
            end else if (flush_i) begin
                m_cancel = 1;
            end
        end else begin
            m_phase = 0;
        end
        if (m_phase == 0) m_cancel = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_stall;
        exp_stall = (m_phase == 1) || (m_phase == 2) ||
                    ((m_phase == 0) && req_en_i && !flush_i);
        chk("rdata",  rdata_o,                     m_rdata);
        chk("stall",  32'(stall_o),                32'(exp_stall));
        chk("bus_req", 32'(bus_req_o),             32'(m_phase == 1));
        chk("bus_wr", 32'(bus_wr_o),               32'(m_we));
        chk("bus_addr", bus_addr_o,                m_addr);
        chk("bus_wstrb", 32'(bus_wstrb_o),         m_we ? 32'(m_sel) : 32'd0);
        chk("bus_wdata", bus_wdata_o,              m_wdata);
    endtask

    // One cycle: inputs already set after the falling edge; check, clock, advance.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic clr();
        rst = 0; req_en_i = 0; req_we_i = 0; flush_i = 0;
        req_addr_i = 0; req_wdata_i = 0; req_sel_i = 0;
        bus_addr_ok_i = 0; bus_data_ok_i = 0; bus_rdata_i = 0;
    endtask

    task automatic set_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel);
        req_en_i = 1; req_we_i = we; req_addr_i = addr;
        req_wdata_i = wdata; req_sel_i = sel;
    endtask

    task automatic set_bus(input logic aok, input logic dok, input logic [31:0] rd);
        bus_addr_ok_i = aok; bus_data_ok_i = dok; bus_rdata_i = rd;
    endtask

    initial begin
        clr();
        model_reset();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        step();
        rst = 0;

        // Reset state
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_bus_req", 32'(bus_req_o), 32'h0);
        step();

        // Spurious data_ok in IDLE and in REQ
        set_bus(0, 1, 32'hAAAA_AAAA);
        step();
        clr(); set_req(0, 32'h2000_0000, 32'h0, 4'hF);
        step();
        clr(); set_bus(0, 1, 32'hBBBB_BBBB);
        step();
        chk("spur_bus_req", 32'(bus_req_o), 32'h1);
        set_bus(1, 0, 0); step();
        set_bus(0, 1, 32'h0000_0000); step();
        clr(); step();

        // Zero-wait load
        set_req(0, 32'h1000_0004, 32'h0, 4'b1111);
        step();
        clr(); set_bus(1, 0, 0); step();
        set_bus(0, 1, 32'hDEAD_BEEF); step();
        clr(); #1;
        chk("load_done_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("load_done_stall", 32'(stall_o), 32'h0);
        step();

        // Byte store with address acceptance delayed three cycles
        set_req(1, 32'h0000_0013, 32'h5A5A_5A5A, 4'b0001);
        step();
        clr();
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("st_wstrb", 32'(bus_wstrb_o), 32'h1);
        chk("st_wr", 32'(bus_wr_o), 32'h1);
        chk("st_rdata", rdata_o, 32'hDEAD_BEEF);
        set_bus(1, 0, 0); step();
        set_bus(0, 1, 32'hDEAD_BEEF); step();
        clr(); step();

        // Flush while waiting for data
        set_req(0, 32'h3000_0000, 32'h0, 4'hF); step();
        clr(); set_bus(1, 0, 0); step();
        clr(); flush_i = 1; step();
        clr(); set_bus(0, 1, 32'h1234_5678); step();
        clr(); #1;
        chk("flush_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("flush_bus_req", 32'(bus_req_o), 32'h0);
        step();

        // Back-to-back loads with req_en held through DONE
        set_req(0, 32'h4000_0000, 32'h0, 4'hF); step();
        set_bus(1, 0, 0); step();
        set_bus(0, 1, 32'h1111_1111); step();
        set_bus(0, 0, 0); set_req(0, 32'h4000_0040, 32'h0, 4'hF); step();
        step();
        #1;
        chk("b2b_bus_req", 32'(bus_req_o), 32'h1);
        chk("b2b_addr", bus_addr_o, 32'h4000_0040);
        clr(); set_bus(1, 0, 0); step();
        set_bus(0, 1, 32'h2222_2222); step();
        clr(); #1;
        chk("b2b_rdata2", rdata_o, 32'h2222_2222);
        step();

        // Reset mid-transaction, then a stray data_ok
        set_req(1, 32'h5000_0000, 32'hCAFE_F00D, 4'b1100); step();
        clr(); set_bus(1, 0, 0); step();
        clr(); rst = 1; step();
        clr(); set_bus(0, 1, 32'h7777_7777); step();
        clr(); #1;
        chk("mrst_rdata", rdata_o, 32'h0);
        chk("mrst_addr", bus_addr_o, 32'h0);
        chk("mrst_wdata", bus_wdata_o, 32'h0);
        step();

        // Random traffic, including stray handshakes and occasional reset
        for (int i = 0; i < 1500; i++) begin
            rst           = ($urandom_range(99) < 2);
            req_en_i      = ($urandom_range(99) < 60);
            req_we_i      = $urandom_range(1);
            req_addr_i    = $urandom;
            req_wdata_i   = $urandom;
            req_sel_i     = 4'($urandom);
            bus_addr_ok_i = ($urandom_range(99) < 40);
            bus_data_ok_i = ($urandom_range(99) < 40);
            bus_rdata_i   = $urandom;
            flush_i       = !bus_data_ok_i && ($urandom_range(99) < 10);
            step();
        end

        clr(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset rst, synchronous, active-high.
REQ-003 req_en_i  input  1  memory access request from the memory stage (ram enable).
REQ-004 req_we_i  input  1  1 = store, 0 = load.
REQ-005 req_addr_i  input  32  byte address, passed unmodified to the bus.
REQ-006 req_wdata_i  input  32  store data, lane-replicated by the memory stage.
REQ-007 req_sel_i  input  4  byte-lane select; bit3 = bits 31:24 ... bit0 = bits 7:0.
REQ-008 flush_i  input  1  pipeline flush (exception/redirect); cancels the current access.
REQ-009 rdata_o  output  32  raw load word returned to the memory stage.
REQ-010 stall_o  output  1  holds the pipeline while an access is in progress.
REQ-011 bus_req_o  output  1  bus request valid.
REQ-012 bus_wr_o  output  1  bus write flag.
REQ-013 bus_addr_o  output  32  bus address.
REQ-014 bus_wstrb_o  output  4  write strobes.
REQ-015 bus_wdata_o  output  32  write data.
REQ-016 bus_addr_ok_i  input  1  bus accepted request this cycle.
REQ-017 bus_data_ok_i  input  1  bus completed the transaction this cycle (read data valid).
REQ-018 bus_rdata_i  input  32  bus read data, valid with bus_data_ok_i.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT and DONE. Encoding is free.
REQ-020 IDLE: req_en_i=1 and flush_i=0 SHALL latch we/addr/wdata/sel into internal registers and move to REQ. Otherwise the FSM SHALL stay in IDLE.
REQ-021 REQ: bus_req_o=1. Bus fields SHALL come only from the latched registers. bus_addr_ok_i=1 SHALL move to WAIT.
REQ-022 A request in REQ SHALL NOT be withdrawn. bus_req_o and all bus fields SHALL stay stable until bus_addr_ok_i.
REQ-023 bus_data_ok_i SHALL be sampled only in WAIT. In WAIT, bus_data_ok_i=1 SHALL capture bus_rdata_i into rdata_q and move to DONE.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE. A new request SHALL be accepted only from IDLE.
REQ-025 stall_o SHALL equal (state==REQ) | (state==WAIT) | (state==IDLE & req_en_i & ~flush_i). stall_o SHALL be 0 in DONE.
REQ-026 rdata_o SHALL equal rdata_q in every state, including stores.
REQ-027 bus_wr_o SHALL equal the latched we.
REQ-028 bus_wstrb_o SHALL equal the latched sel when we=1, and 4'b0000 when we=0.
REQ-029 bus_wdata_o SHALL equal the latched wdata.
REQ-030 Outside REQ, bus_req_o SHALL be 0. The other bus fields hold their latched values.
REQ-031 Minimum load/store latency: request seen in cycle n; addr_ok in n+1; data_ok in n+2; DONE in n+3. stall_o is high in n..n+2.
REQ-032 flush_i in IDLE SHALL suppress acceptance.
REQ-033 flush_i in REQ or WAIT SHALL set the cancel flag. The outstanding transaction SHALL still run to data_ok.
REQ-034 With the cancel flag set, WAIT+data_ok SHALL go directly to IDLE. In that case rdata_q SHALL NOT be updated and DONE SHALL be skipped.
REQ-035 The cancel flag SHALL clear on entry to IDLE.
REQ-036 flush_i in DONE SHALL have no effect; DONE→IDLE still occurs.
REQ-037 bus_addr_ok_i or bus_data_ok_i asserted in any state other than the one that samples it SHALL be ignored.
REQ-038 Address alignment SHALL NOT be checked; misalignment is the memory stage's concern.

Reset
REQ-039 rst=1 at a clock edge SHALL force state=IDLE and clear the cancel flag.
REQ-040 The same rst edge SHALL clear rdata_q and all latched request registers, giving rdata_o=0, stall_o=0 (with req_en_i=0), bus_req_o=0, bus_wr_o=0, bus_addr_o=0, bus_wstrb_o=0 and bus_wdata_o=0.
REQ-041 rst SHALL take priority over every other input, including mid-transaction. The bus is assumed reset together with the block.

Verification
REQ-042 Load, zero-wait bus: addr 0x1000_0004, sel 4'b1111, addr_ok in n+1, data_ok with 0xDEADBEEF in n+2 -> stall_o=1 for n..n+2; DONE in n+3 with rdata_o=0xDEADBEEF and stall_o=0.
REQ-043 Store byte: addr 0x0000_0013, sel 4'b0001, wdata 0x5A5A5A5A, addr_ok delayed 3 cycles -> bus_req_o and fields stable for 3 cycles; bus_wstrb_o=4'b0001 and bus_wr_o=1; rdata_o unchanged.
REQ-044 Flush in WAIT: load in flight, flush_i pulsed, then data_ok with 0x12345678 -> no DONE cycle, rdata_o keeps its previous value, next cycle IDLE.
REQ-045 Back-to-back: two loads with req_en_i held high across DONE -> the second request is latched in the cycle after DONE; no bus_req_o in DONE; two distinct rdata values are returned.
REQ-046 Reset mid-operation: rst asserted in WAIT -> next cycle IDLE with all outputs 0; a data_ok arriving afterwards is ignored.
REQ-047 Spurious handshake: data_ok asserted in IDLE and REQ -> no state change and rdata_o unchanged.
